mem_port_arbiter: RTL and testbench

Shares the core's single 32-bit, byte-lane memory port between two requesters: instruction fetch (IF) and load/store (LS). It arbitrates with a fixed-latency request/grant/response handshake, with LS priority and a starvation guard for fetch. It stops granting new accesses once `halted` is raised. It sits between the core's fetch/LSU logic and the memory model's `mem_addr` / `mem_data_in` / `mem_data_out` / `mem_write_en` pins.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 32-bit byte-lane memory port.
// Load/store has priority; fetch is forced through after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned MAX_WAIT    = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halted,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [7:0]  mem_data_in [0:3],
    input  logic [7:0]  mem_data_out [0:3],
    output logic        busy
);

    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [WW-1:0] wait_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          owner_ls_q;
    logic [31:0]   rd_next;

    // Grants are gated by rst_b so every output reads 0 while reset is held.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_b && !halted && (if_req || ls_req)) begin
                    if (if_req && (!ls_req || wait_q == WAIT_MAX)) begin
                        if_gnt = 1'b1;
                    end else begin
                        ls_gnt = 1'b1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_next = we_q ? '0 : {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_ls_q <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (if_gnt || ls_gnt) begin
                addr_q     <= ls_gnt ? ls_addr : if_addr;
                wdata_q    <= ls_gnt ? ls_wdata : '0;
                we_q       <= ls_gnt & ls_we;
                owner_ls_q <= ls_gnt;
                cnt_q      <= CNT_INIT;
                if (if_gnt) begin
                    wait_q <= '0;
                end else if (if_req && wait_q != WAIT_MAX) begin
                    wait_q <= wait_q + WAIT_ONE;
                end
            end
            if (state_q == ACCESS) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end else if (owner_ls_q) begin
                    ls_rdata <= rd_next;
                end else begin
                    if_rdata <= rd_next;
                end
            end
        end
    end

    // The latches only change on a grant, so they double as the held port values.
    assign mem_addr       = addr_q;
    assign mem_data_in[0] = wdata_q[7:0];
    assign mem_data_in[1] = wdata_q[15:8];
    assign mem_data_in[2] = wdata_q[23:16];
    assign mem_data_in[3] = wdata_q[31:24];
    assign mem_write_en   = (state_q == ACCESS) && we_q && (cnt_q == CNT_INIT);
    assign if_rvalid      = (state_q == RESP) && !owner_ls_q;
    assign ls_rvalid      = (state_q == RESP) && owner_ls_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LATENCY=1 and one at 3,
// each driven by its own requesters and checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MW   = 3;
    localparam int NCYC = 1300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_b, halted, if_req, ls_req, ls_we;
    logic [1:0]  if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_write_en, busy;
    logic [31:0] if_addr [2];
    logic [31:0] ls_addr [2];
    logic [31:0] ls_wdata [2];
    logic [31:0] if_rdata [2];
    logic [31:0] ls_rdata [2];
    logic [31:0] mem_addr [2];
    logic [7:0]  mdi0 [0:3];
    logic [7:0]  mdi1 [0:3];
    logic [7:0]  mdo0 [0:3];
    logic [7:0]  mdo1 [0:3];
    int          cyc = 0;

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(MW)) u_l1 (
        .clk(clk), .rst_b(rst_b[0]), .halted(halted[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
        .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_write_en(mem_write_en[0]),
        .mem_data_in(mdi0), .mem_data_out(mdo0), .busy(busy[0])
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .MAX_WAIT(MW)) u_l3 (
        .clk(clk), .rst_b(rst_b[1]), .halted(halted[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
        .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_write_en(mem_write_en[1]),
        .mem_data_in(mdi1), .mem_data_out(mdo1), .busy(busy[1])
    );

    // Memory: upper-half addresses mix in the cycle number so the capture cycle is visible.
    function automatic logic [31:0] rom(input logic [31:0] a, input int c);
        if (a == 32'h100) return 32'h13;
        return (a * 32'h9E37_79B1 + 32'h0123_4567) ^ (a[31] ? (32'(c) << 8) : 32'h0);
    endfunction

    always_comb begin
        {mdo0[3], mdo0[2], mdo0[1], mdo0[0]} = rom(mem_addr[0], cyc);
        {mdo1[3], mdo1[2], mdo1[1], mdo1[0]} = rom(mem_addr[1], cyc);
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    typedef struct {
        int          k;
        logic        ig, lg, bz, we;
        logic [31:0] ma, md, ird, lrd;
    } cyc_exp_t;

    typedef struct {
        int          k;
        logic        ls;
        logic [31:0] data;
        int          due;
    } resp_t;

    cyc_exp_t exp_q [$];
    resp_t    resp_q [$];
    int       ord_q [$];
    int       n_chk = 0;
    int       n_fail = 0;

    // Requester and model state, per instance.
    logic        if_pend [2], ls_pend [2], g_if [2], g_ls [2];
    logic        act [2], a_we [2], a_ls [2];
    int          t_g [2], waitc [2], rst_at [2];
    logic [31:0] a_data [2], e_ird [2], e_lrd [2], last_addr [2], last_wd [2];

    task automatic chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL k%0d %s @cyc %0d: got %h expected %h", k, nm, cyc, got, want);
        end
    endtask

    task automatic drive(input int k, input int n);
        logic do_if, do_ls, w;
        logic [31:0] ia, la, ld;
        if (g_if[k]) if_pend[k] = 1'b0;
        if (g_ls[k]) ls_pend[k] = 1'b0;
        rst_b[k] = (n >= 4) && !(rst_at[k] >= 0 && n >= rst_at[k] && n < rst_at[k] + 3);
        if (n >= 121 && n < 140) halted[k] = 1'b1;
        else if (n >= 250 && n < NCYC - 40) begin
            if ($urandom_range(0, 9) == 0) halted[k] = ~halted[k];
        end else halted[k] = 1'b0;
        do_if = 1'b0; do_ls = 1'b0;
        ia = $urandom; la = $urandom; ld = $urandom; w = 1'($urandom_range(0, 1));
        if (n == 5) begin do_if = 1'b1; ia = 32'h100; end
        if (n == 20) begin do_ls = 1'b1; w = 1'b1; la = 32'h20; ld = 32'hDEAD_BEEF; end
        if ((n >= 40 && n < 100) || (n >= 150 && n < 250)) begin do_if = 1'b1; do_ls = 1'b1; end
        if (n == 120) begin do_ls = 1'b1; w = 1'b0; la = 32'h8000_0040; end
        if (n == 122) do_if = 1'b1;
        if (n == 125) do_ls = 1'b1;
        if (n >= 250 && n < NCYC - 40) begin
            do_if = ($urandom_range(0, 2) == 0);
            do_ls = ($urandom_range(0, 2) == 0);
        end
        if (!if_pend[k] && do_if) begin if_pend[k] = 1'b1; if_addr[k] = ia; end
        if (!ls_pend[k] && do_ls) begin
            ls_pend[k] = 1'b1; ls_addr[k] = la; ls_wdata[k] = ld; ls_we[k] = w;
        end
        if_req[k] = if_pend[k];
        ls_req[k] = ls_pend[k];
    endtask

    task automatic model(input int k, input int n);
        cyc_exp_t e;
        resp_t    r;
        int       L;
        L = lat_of(k);
        e = '{default: '0};
        e.k = k;
        g_if[k] = 1'b0; g_ls[k] = 1'b0;
        if (!rst_b[k]) begin
            act[k] = 1'b0; waitc[k] = 0;
            e_ird[k] = '0; e_lrd[k] = '0; last_addr[k] = '0; last_wd[k] = '0;
            for (int i = resp_q.size() - 1; i >= 0; i--)
                if (resp_q[i].k == k) resp_q.delete(i);
            exp_q.push_back(e);
            return;
        end
        if (act[k] && n >= t_g[k] + L + 2) act[k] = 1'b0;
        e.bz = act[k];
        e.we = act[k] && a_we[k] && (n == t_g[k] + 1);
        if (act[k] && n == t_g[k] + L + 1) begin
            if (a_ls[k]) e_lrd[k] = a_data[k]; else e_ird[k] = a_data[k];
        end
        e.ma = last_addr[k];
        e.md = last_wd[k];
        if (!act[k] && !halted[k] && (if_req[k] || ls_req[k])) begin
            if (if_req[k] && (!ls_req[k] || waitc[k] == MW)) begin
                g_if[k] = 1'b1; waitc[k] = 0;
                a_ls[k] = 1'b0; a_we[k] = 1'b0;
                last_addr[k] = if_addr[k]; last_wd[k] = '0;
            end else begin
                g_ls[k] = 1'b1;
                if (if_req[k] && waitc[k] < MW) waitc[k]++;
                a_ls[k] = 1'b1; a_we[k] = ls_we[k];
                last_addr[k] = ls_addr[k]; last_wd[k] = ls_wdata[k];
                if (n >= 150 && rst_at[k] < 0 && waitc[k] == MW) rst_at[k] = n + 1;
            end
            act[k] = 1'b1; t_g[k] = n;
            a_data[k] = a_we[k] ? '0 : rom(last_addr[k], n + L);
            r.k = k; r.ls = a_ls[k]; r.data = a_data[k]; r.due = n + L + 1;
            resp_q.push_back(r);
        end
        e.ig = g_if[k]; e.lg = g_ls[k];
        e.ird = e_ird[k]; e.lrd = e_lrd[k];
        exp_q.push_back(e);
    endtask

    // Monitor: pops per-cycle expectations and matches responses when rvalid appears.
    always @(negedge clk) begin
        cyc_exp_t e;
        resp_t    r;
        int       idx;
        logic [31:0] md;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            md = (e.k == 0) ? {mdi0[3], mdi0[2], mdi0[1], mdi0[0]} : {mdi1[3], mdi1[2], mdi1[1], mdi1[0]};
            chk(e.k, "if_gnt", 32'(if_gnt[e.k]), 32'(e.ig));
            chk(e.k, "ls_gnt", 32'(ls_gnt[e.k]), 32'(e.lg));
            chk(e.k, "busy", 32'(busy[e.k]), 32'(e.bz));
            chk(e.k, "mem_write_en", 32'(mem_write_en[e.k]), 32'(e.we));
            chk(e.k, "mem_addr", mem_addr[e.k], e.ma);
            chk(e.k, "mem_data_in", md, e.md);
            chk(e.k, "if_rdata", if_rdata[e.k], e.ird);
            chk(e.k, "ls_rdata", ls_rdata[e.k], e.lrd);
        end
        for (int k = 0; k < 2; k++) begin
            idx = -1;
            for (int i = 0; i < resp_q.size(); i++)
                if (idx < 0 && resp_q[i].k == k) idx = i;
            if (if_rvalid[k] || ls_rvalid[k]) begin
                if (idx < 0) begin
                    chk(k, "unexpected_rvalid", {if_rvalid[k], ls_rvalid[k]}, 32'h0);
                end else begin
                    r = resp_q[idx];
                    resp_q.delete(idx);
                    chk(k, "rvalid_owner", {if_rvalid[k], ls_rvalid[k]}, r.ls ? 32'h1 : 32'h2);
                    chk(k, "rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk(k, "rdata", r.ls ? ls_rdata[k] : if_rdata[k], r.data);
                end
            end else if (idx >= 0 && resp_q[idx].due <= cyc) begin
                chk(k, "missing_rvalid", 32'h0, 32'h1);
                resp_q.delete(idx);
            end
            if (cyc >= 40 && cyc < 100 && (if_gnt[k] || ls_gnt[k]))
                ord_q.push_back(k * 2 + int'(ls_gnt[k]));
        end
    end

    initial begin
        int pat [8];
        int cnt;
        pat = '{1, 1, 1, 0, 1, 1, 1, 0};
        rst_b = '0; halted = '0; if_req = '0; ls_req = '0; ls_we = '0;
        for (int k = 0; k < 2; k++) begin
            if_addr[k] = '0; ls_addr[k] = '0; ls_wdata[k] = '0;
            if_pend[k] = 1'b0; ls_pend[k] = 1'b0; g_if[k] = 1'b0; g_ls[k] = 1'b0;
            act[k] = 1'b0; a_we[k] = 1'b0; a_ls[k] = 1'b0;
            t_g[k] = 0; waitc[k] = 0; rst_at[k] = -1; a_data[k] = '0;
            e_ird[k] = '0; e_lrd[k] = '0; last_addr[k] = '0; last_wd[k] = '0;
        end
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            cyc = n;
            for (int k = 0; k < 2; k++) begin
                drive(k, n);
                model(k, n);
            end
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            foreach (ord_q[i]) begin
                if (ord_q[i] / 2 == k && cnt < 8) begin
                    chk(k, "contention_order", 32'(ord_q[i] % 2), 32'(pat[cnt]));
                    cnt++;
                end
            end
            chk(k, "contention_grants", 32'(cnt), 32'd8);
            chk(k, "reset_triggered", 32'(rst_at[k] >= 0), 32'd1);
        end
        chk(0, "responses_drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
